// File: rtl/banco_registros_if.sv
// Register-file bus: read ports, write-back port, reservation and stall.
// Master is the issue/write-back side, slave is the register file.
interface banco_registros_if;
   logic [4:0]  RA1;
   logic [4:0]  RA2;
   logic [31:0] RD1;
   logic [31:0] RD2;
   logic        WE;
   logic [4:0]  WA;
   logic [31:0] WD;
   logic        Reservar;
   logic [4:0]  RDest;
   logic        Stall;

   modport master (
      output RA1, RA2, WE, WA, WD, Reservar, RDest,
      input  RD1, RD2, Stall
   );

   modport slave (
      input  RA1, RA2, WE, WA, WD, Reservar, RDest,
      output RD1, RD2, Stall
   );
endinterface

// File: rtl/banco_registros.sv
// 32x32 register file with per-register busy scoreboard and issue stall.
// Optional write-first bypass selected by macro BANCO_BYPASS_EN.
module banco_registros (
   input  logic             clk,
   input  logic             rst,
   banco_registros_if.slave bus
);

   logic [31:0] regs_q [32];
   logic [31:0] regs_d [32];
   logic [31:0] busy_q;
   logic [31:0] busy_d;

   // Next state: write-back, busy clear, then reservation set (set wins)
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      if (bus.WE && (bus.WA != 5'd0)) begin
         regs_d[bus.WA] = bus.WD;
      end
      if (bus.WE) begin
         busy_d[bus.WA] = 1'b0;
      end
      if (bus.Reservar && (bus.RDest != 5'd0)) begin
         busy_d[bus.RDest] = 1'b1;
      end
      regs_d[0] = 32'd0;
      busy_d[0] = 1'b0;
   end

   // State registers; reset dominates any same-cycle write or reservation
   always_ff @(posedge clk) begin
      if (rst) begin
         regs_q <= '{default: 32'd0};
         busy_q <= 32'd0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

`ifdef BANCO_BYPASS_EN
   logic hit1;
   logic hit2;

   // Same-cycle write to a read address forwards WD and hides its busy bit
   always_comb begin
      hit1 = bus.WE && (bus.WA != 5'd0) && (bus.WA == bus.RA1);
      hit2 = bus.WE && (bus.WA != 5'd0) && (bus.WA == bus.RA2);
      bus.RD1 = 32'd0;
      bus.RD2 = 32'd0;
      if (bus.RA1 != 5'd0) begin
         bus.RD1 = hit1 ? bus.WD : regs_q[bus.RA1];
      end
      if (bus.RA2 != 5'd0) begin
         bus.RD2 = hit2 ? bus.WD : regs_q[bus.RA2];
      end
      bus.Stall = (busy_q[bus.RA1] && !hit1)
               || (busy_q[bus.RA2] && !hit2);
   end
`else
   // Plain reads: old value shown during the write cycle, stall held
   always_comb begin
      bus.RD1 = 32'd0;
      bus.RD2 = 32'd0;
      if (bus.RA1 != 5'd0) begin
         bus.RD1 = regs_q[bus.RA1];
      end
      if (bus.RA2 != 5'd0) begin
         bus.RD2 = regs_q[bus.RA2];
      end
      bus.Stall = busy_q[bus.RA1] || busy_q[bus.RA2];
   end
`endif

endmodule
